ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline, directly downstream of the ALU decoder.
- Holds the ID/EX pipeline register, performs operand forwarding, and runs the ALU on the 3-bit alu_control code.
- Resolves branches and jumps, and drives the EX/MEM pipeline register consumed by the memory stage.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold ID/EX contents.
- flush  in  1  load a bubble into ID/EX.
- id_valid  in  1  decode-stage instruction valid.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data / id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1 / id_rs2 / id_rd  in  RA_W  register addresses.
- id_alu_control  in  3  ALU operation code from the ALU decoder.
- id_alu_src  in  1  1 = use immediate as operand B.
- id_reg_write / id_mem_write / id_branch / id_jump  in  1  control bits.
- id_result_src  in  2  00 ALU, 01 load, 10 pc+4.
- wb_rd  in  RA_W  writeback destination.
- wb_reg_write  in  1  writeback write enable.
- wb_data  in  XLEN  writeback result.
- pc_src  out  1  redirect fetch.
- pc_target  out  XLEN  redirect address.
- ex_rs1 / ex_rs2 / ex_rd  out  RA_W  ID/EX addresses, for the hazard unit.
- ex_is_load  out  1  ID/EX holds a valid load.
- mem_valid  out  1  EX/MEM valid.
- mem_alu_result / mem_write_data / mem_pc_plus4  out  XLEN  EX/MEM data.
- mem_rd  out  RA_W  EX/MEM destination.
- mem_reg_write / mem_mem_write  out  1  EX/MEM controls.
- mem_result_src  out  2  EX/MEM result select.

Behaviour:
- Reset: rst asserts asynchronously and clears both register banks to zero. All mem_* outputs, ex_* outputs, pc_src and pc_target read 0 while rst is high.
- ID/EX capture, per clock edge, in priority order:
  - flush=1: bubble (valid, reg_write, mem_write, branch, jump = 0; data fields don't-care). Flush wins over stall.
  - else stall=1: hold all contents.
  - else: capture all id_* inputs.
- EX/MEM capture: never stalls. Captures every cycle. If ID/EX is not valid, captures a bubble (mem_valid=0, mem_reg_write=0, mem_mem_write=0).
- Latency: an instruction presented on id_* at edge N appears on mem_* after edge N+1.
- Forwarding, per operand independently:
  - Source 1, highest priority: EX/MEM, when mem_reg_write & mem_valid & mem_rd!=0 & mem_rd==ex_rsX, selects mem_alu_result.
  - Source 2: WB, when wb_reg_write & wb_rd!=0 & wb_rd==ex_rsX, selects wb_data.
  - Otherwise: the registered read data.
  - Register x0 is never forwarded.
- Operand B is the immediate when alu_src=1. mem_write_data is always the forwarded rs2 value.
- ALU codes:
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 101 slt, signed, result 1 or 0.
  - Any other code gives result 0.
  - Wrap-around is modulo 2^XLEN with no overflow flag.
  - zero = (result==0).
- Branch resolution (combinational from ID/EX):
  - pc_target = ex_pc + ex_imm, modulo 2^XLEN.
  - pc_src = ex_valid & (jump | (branch & zero)).
  - ex_is_load = ex_valid & (result_src==01).
- mem_pc_plus4 = ex_pc + 4.
- Reset asserted mid-operation discards all in-flight instructions. The first post-reset cycle is a bubble.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined: forwarding network as above.
- Undefined:
  - The forwarding muxes are removed and operands always come from the registered read data.
  - wb_* inputs are ignored.
  - The hazard unit must stall on all RAW dependencies.
  - Ports are unchanged.

Decomposition:
- Shared package rv_pkg holds:
  - alu_ctrl_e enum (ADD=000, SUB=001, AND=010, OR=011, SLT=101).
  - result_src_e enum (RES_ALU, RES_LOAD, RES_PC4).
  - fwd_sel_e enum (FWD_REG, FWD_MEM, FWD_WB).
  - Packed structs id_ex_t and ex_mem_t.
- One sub-module, alu: combinational, inputs a, b, alu_control; outputs result, zero.

Test Plan:
- Add: id add, rs1=5, rs2=7, alu_src=0, rd=3, presented once → one edge later mem_alu_result=12, mem_rd=3, mem_valid=1, mem_reg_write=1.
- Branch taken: beq (alu_control=001, branch=1) with both operands 0x40, id_pc=0x100, imm=0x20 → pc_src=1, pc_target=0x120 while in EX. Same with operands 0x40/0x41 → pc_src=0.
- Forwarding: add x1←3+4, then add x2←x1+x1 back-to-back with stale x1=0 → second result 14. Repeat as WB-distance forward (one bubble between) → 14. With EX_FWD_EN undefined → 0.
- slt and x0: slt -3 vs 2 → 1; slt 2 vs -3 → 0. Writes to rd=0 followed by a dependent read of x0 → no forwarding, operand 0.
- Flush/stall: flush and stall asserted together with a valid id_* → mem_valid=0 next cycle. Stall alone for 3 cycles → ID/EX content unchanged and reproduced on mem_* each cycle.
- Reset mid-operation: assert rst asynchronously between edges during a pipelined stream → all mem_* and pc_src go 0 immediately. After release, the first cycle is mem_valid=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the RV32I execute stage: ALU codes, result select,
// forwarding selects and the ID/EX and EX/MEM pipeline register layouts.
// Also holds the operand-forwarding priority helper.
package rv_pkg;

  localparam int RV_XLEN = 32;
  localparam int RV_RA_W = 5;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] rs1_data;
    logic [RV_XLEN-1:0] rs2_data;
    logic [RV_XLEN-1:0] imm;
    logic [RV_RA_W-1:0] rs1;
    logic [RV_RA_W-1:0] rs2;
    logic [RV_RA_W-1:0] rd;
    logic [2:0]         alu_control;
    logic               alu_src;
    logic               reg_write;
    logic               mem_write;
    logic               branch;
    logic               jump;
    logic [1:0]         result_src;
  } id_ex_t;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] alu_result;
    logic [RV_XLEN-1:0] write_data;
    logic [RV_XLEN-1:0] pc_plus4;
    logic [RV_RA_W-1:0] rd;
    logic               reg_write;
    logic               mem_write;
    logic [1:0]         result_src;
  } ex_mem_t;

  // Younger producer (EX/MEM) beats older one (WB); x0 is never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [RV_RA_W-1:0] rs,
    input logic               mem_en,
    input logic [RV_RA_W-1:0] mem_rd,
    input logic               wb_en,
    input logic [RV_RA_W-1:0] wb_rd
  );
    fwd_select = FWD_REG;
    if (rs != '0) begin
      if (mem_en && (mem_rd == rs)) begin
        fwd_select = FWD_MEM;
      end else if (wb_en && (wb_rd == rs)) begin
        fwd_select = FWD_WB;
      end
    end
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Purpose: RV32I execute ALU (add, sub, and, or, signed slt) with zero flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module alu
  import rv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Select the operation; undefined codes produce zero. Arithmetic wraps.
  always_comb begin
    result = '0;
    case (alu_control)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      SLT:     result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Purpose: RV32I execute stage - ID/EX register, forwarding, ALU, branch resolve, EX/MEM register.
// Latency: id_* captured at edge N appears on mem_* after edge N+1; branch outputs combinational from ID/EX.
// Backpressure: stall holds ID/EX, flush bubbles it (flush wins); EX/MEM never stalls. Macro EX_FWD_EN enables forwarding.
module ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int RA_W = RV_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [1:0]      id_result_src,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_is_load,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_write_data,
  output logic [XLEN-1:0] mem_pc_plus4,
  output logic [RA_W-1:0] mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_write,
  output logic [1:0]      mem_result_src
);

  id_ex_t          r_id_ex;
  id_ex_t          w_id_ex_nxt;
  ex_mem_t         r_ex_mem;
  ex_mem_t         w_ex_mem_nxt;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;

  // Pack decode-stage inputs into the ID/EX layout.
  always_comb begin
    w_id_ex_nxt             = '0;
    w_id_ex_nxt.valid       = id_valid;
    w_id_ex_nxt.pc          = id_pc;
    w_id_ex_nxt.rs1_data    = id_rs1_data;
    w_id_ex_nxt.rs2_data    = id_rs2_data;
    w_id_ex_nxt.imm         = id_imm;
    w_id_ex_nxt.rs1         = id_rs1;
    w_id_ex_nxt.rs2         = id_rs2;
    w_id_ex_nxt.rd          = id_rd;
    w_id_ex_nxt.alu_control = id_alu_control;
    w_id_ex_nxt.alu_src     = id_alu_src;
    w_id_ex_nxt.reg_write   = id_reg_write;
    w_id_ex_nxt.mem_write   = id_mem_write;
    w_id_ex_nxt.branch      = id_branch;
    w_id_ex_nxt.jump        = id_jump;
    w_id_ex_nxt.result_src  = id_result_src;
  end

  // ID/EX register: flush loads an all-zero bubble and overrides stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_ex <= '0;
    end else if (flush) begin
      r_id_ex <= '0;
    end else if (!stall) begin
      r_id_ex <= w_id_ex_nxt;
    end
  end

`ifdef EX_FWD_EN
  fwd_sel_e w_fwd_a_sel;
  fwd_sel_e w_fwd_b_sel;
  logic     w_mem_fwd_en;

  assign w_mem_fwd_en = r_ex_mem.valid & r_ex_mem.reg_write;
  assign w_fwd_a_sel  = fwd_select(r_id_ex.rs1, w_mem_fwd_en, r_ex_mem.rd, wb_reg_write, wb_rd);
  assign w_fwd_b_sel  = fwd_select(r_id_ex.rs2, w_mem_fwd_en, r_ex_mem.rd, wb_reg_write, wb_rd);

  // Operand muxes: pick the youngest in-flight value for each source register.
  always_comb begin
    w_op_a = r_id_ex.rs1_data;
    w_op_b = r_id_ex.rs2_data;
    case (w_fwd_a_sel)
      FWD_MEM: w_op_a = r_ex_mem.alu_result;
      FWD_WB:  w_op_a = wb_data;
      default: w_op_a = r_id_ex.rs1_data;
    endcase
    case (w_fwd_b_sel)
      FWD_MEM: w_op_b = r_ex_mem.alu_result;
      FWD_WB:  w_op_b = wb_data;
      default: w_op_b = r_id_ex.rs2_data;
    endcase
  end
`else
  // Without forwarding the hazard unit stalls every RAW, so WB is not needed here.
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_rd, wb_reg_write, wb_data};
  assign w_op_a      = r_id_ex.rs1_data;
  assign w_op_b      = r_id_ex.rs2_data;
`endif

  assign w_alu_b = r_id_ex.alu_src ? r_id_ex.imm : w_op_b;

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a          (w_op_a),
    .b          (w_alu_b),
    .alu_control(r_id_ex.alu_control),
    .result     (w_alu_result),
    .zero       (w_alu_zero)
  );

  // Build the EX/MEM word; an invalid ID/EX slot becomes a bubble.
  always_comb begin
    w_ex_mem_nxt            = '0;
    w_ex_mem_nxt.valid      = r_id_ex.valid;
    w_ex_mem_nxt.alu_result = w_alu_result;
    w_ex_mem_nxt.write_data = w_op_b;
    w_ex_mem_nxt.pc_plus4   = r_id_ex.pc + XLEN'(4);
    w_ex_mem_nxt.rd         = r_id_ex.rd;
    w_ex_mem_nxt.reg_write  = r_id_ex.valid & r_id_ex.reg_write;
    w_ex_mem_nxt.mem_write  = r_id_ex.valid & r_id_ex.mem_write;
    w_ex_mem_nxt.result_src = r_id_ex.result_src;
  end

  // EX/MEM register: loads every cycle, never held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_mem <= '0;
    end else begin
      r_ex_mem <= w_ex_mem_nxt;
    end
  end

  assign pc_target  = r_id_ex.pc + r_id_ex.imm;
  assign pc_src     = r_id_ex.valid & (r_id_ex.jump | (r_id_ex.branch & w_alu_zero));
  assign ex_is_load = r_id_ex.valid & (r_id_ex.result_src == RES_LOAD);
  assign ex_rs1     = r_id_ex.rs1;
  assign ex_rs2     = r_id_ex.rs2;
  assign ex_rd      = r_id_ex.rd;

  assign mem_valid      = r_ex_mem.valid;
  assign mem_alu_result = r_ex_mem.alu_result;
  assign mem_write_data = r_ex_mem.write_data;
  assign mem_pc_plus4   = r_ex_mem.pc_plus4;
  assign mem_rd         = r_ex_mem.rd;
  assign mem_reg_write  = r_ex_mem.reg_write;
  assign mem_mem_write  = r_ex_mem.mem_write;
  assign mem_result_src = r_ex_mem.result_src;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic, all checked
// against a behavioural pipeline model. Honours EX_FWD_EN like the design.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_alu_control;
  logic        id_alu_src, id_reg_write, id_mem_write, id_branch, id_jump;
  logic [1:0]  id_result_src;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_is_load;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus4;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_write;
  logic [1:0]  mem_result_src;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_jump(id_jump), .id_result_src(id_result_src),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .pc_src(pc_src), .pc_target(pc_target), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src)
  );

`ifdef EX_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct {
    bit          v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  ctl;
    bit          src, rw, mw, br, jp;
    logic [1:0]  rsrc;
  } ins_t;

  typedef struct {
    bit          v;
    logic [31:0] res, wd, pc4;
    logic [4:0]  rd;
    bit          rw, mw;
    logic [1:0]  rsrc;
  } slot_t;

  ins_t  m_ex;
  slot_t m_mem;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU from the operation table, signed compare via int.
  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Architectural value of a source register as seen by the instruction in EX.
  function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] stale);
    if (FWD_ON && rs != 5'd0) begin
      if (m_mem.v && m_mem.rw && m_mem.rd == rs) return m_mem.res;
      if (wb_reg_write && wb_rd == rs) return wb_data;
    end
    return stale;
  endfunction

  function automatic logic [31:0] ex_result();
    logic [31:0] a, b;
    a = src_val(m_ex.rs1, m_ex.d1);
    b = m_ex.src ? m_ex.imm : src_val(m_ex.rs2, m_ex.d2);
    return ref_alu(m_ex.ctl, a, b);
  endfunction

  task automatic check_all();
    logic exp_pc_src;
    exp_pc_src = m_ex.v && (m_ex.jp || (m_ex.br && ex_result() == 32'd0));
    chk("mem_valid", mem_valid, m_mem.v);
    chk("mem_reg_write", mem_reg_write, m_mem.rw);
    chk("mem_mem_write", mem_mem_write, m_mem.mw);
    if (m_mem.v) begin
      chk("mem_alu_result", mem_alu_result, m_mem.res);
      chk("mem_write_data", mem_write_data, m_mem.wd);
      chk("mem_pc_plus4", mem_pc_plus4, m_mem.pc4);
      chk("mem_rd", mem_rd, m_mem.rd);
      chk("mem_result_src", mem_result_src, m_mem.rsrc);
    end
    chk("pc_src", pc_src, exp_pc_src);
    chk("ex_is_load", ex_is_load, m_ex.v && m_ex.rsrc == 2'b01);
    if (m_ex.v) begin
      chk("pc_target", pc_target, m_ex.pc + m_ex.imm);
      chk("ex_rs1", ex_rs1, m_ex.rs1);
      chk("ex_rs2", ex_rs2, m_ex.rs2);
      chk("ex_rd", ex_rd, m_ex.rd);
    end
  endtask

  // One clock: model advances with the same inputs the DUT samples.
  task automatic step();
    ins_t  nin;
    slot_t nm;
    nin.v = id_valid; nin.pc = id_pc; nin.d1 = id_rs1_data; nin.d2 = id_rs2_data;
    nin.imm = id_imm; nin.rs1 = id_rs1; nin.rs2 = id_rs2; nin.rd = id_rd;
    nin.ctl = id_alu_control; nin.src = id_alu_src; nin.rw = id_reg_write;
    nin.mw = id_mem_write; nin.br = id_branch; nin.jp = id_jump; nin.rsrc = id_result_src;
    nm.v = m_ex.v; nm.rw = m_ex.v && m_ex.rw; nm.mw = m_ex.v && m_ex.mw;
    nm.res = ex_result(); nm.wd = src_val(m_ex.rs2, m_ex.d2);
    nm.pc4 = m_ex.pc + 32'd4; nm.rd = m_ex.rd; nm.rsrc = m_ex.rsrc;
    @(posedge clk);
    m_mem = nm;
    if (flush) m_ex = '{default: 0};
    else if (!stall) m_ex = nin;
    #1;
    check_all();
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = 0; id_alu_src = 0;
    id_reg_write = 0; id_mem_write = 0; id_branch = 0; id_jump = 0; id_result_src = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic put(input logic [2:0] ctl, input logic [4:0] rs1, input logic [31:0] d1,
                     input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd);
    id_valid = 1; id_alu_control = ctl; id_rs1 = rs1; id_rs1_data = d1;
    id_rs2 = rs2; id_rs2_data = d2; id_rd = rd; id_reg_write = 1; id_alu_src = 0;
    id_mem_write = 0; id_branch = 0; id_jump = 0; id_result_src = 0; id_imm = 0; id_pc = 32'h1000;
  endtask

  function automatic logic [31:0] rand_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'(int'($urandom_range(0, 16)) - 8);
  endfunction

  initial begin
    clr_in();
    m_ex  = '{default: 0};
    m_mem = '{default: 0};
    #7;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_alu_result", mem_alu_result, 0);
    chk("rst_mem_pc_plus4", mem_pc_plus4, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_ex_rd", ex_rd, 0);
    @(negedge clk);
    rst = 0;

    // add x3 <- 5 + 7
    put(3'b000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
    step();
    clr_in();
    step();
    chk("add_res", mem_alu_result, 32'd12);
    chk("add_rd", mem_rd, 5'd3);
    chk("add_valid", mem_valid, 1);
    chk("add_rw", mem_reg_write, 1);

    // beq taken / not taken
    put(3'b001, 5'd4, 32'h40, 5'd5, 32'h40, 5'd0);
    id_reg_write = 0; id_branch = 1; id_pc = 32'h100; id_imm = 32'h20;
    step();
    chk("beq_taken", pc_src, 1);
    chk("beq_target", pc_target, 32'h120);
    id_rs2_data = 32'h41;
    step();
    chk("beq_not_taken", pc_src, 0);

    // EX/MEM-distance forward: x1 <- 3+4 ; x2 <- x1+x1 with stale x1 = 0
    put(3'b000, 5'd6, 32'd3, 5'd7, 32'd4, 5'd1);
    step();
    put(3'b000, 5'd1, 32'd0, 5'd1, 32'd0, 5'd2);
    step();
    clr_in();
    step();
    chk("fwd_mem", mem_alu_result, FWD_ON ? 32'd14 : 32'd0);

    // WB-distance forward: one bubble between producer and consumer
    put(3'b000, 5'd6, 32'd3, 5'd7, 32'd4, 5'd1);
    step();
    clr_in();
    step();
    put(3'b000, 5'd1, 32'd0, 5'd1, 32'd0, 5'd2);
    step();
    clr_in();
    wb_rd = 5'd1; wb_reg_write = 1; wb_data = 32'd7;
    step();
    chk("fwd_wb", mem_alu_result, FWD_ON ? 32'd14 : 32'd0);
    clr_in();

    // signed slt
    put(3'b101, 5'd8, 32'hFFFF_FFFD, 5'd9, 32'd2, 5'd10);
    step();
    put(3'b101, 5'd8, 32'd2, 5'd9, 32'hFFFF_FFFD, 5'd10);
    step();
    chk("slt_neg_lt_pos", mem_alu_result, 32'd1);
    clr_in();
    step();
    chk("slt_pos_lt_neg", mem_alu_result, 32'd0);

    // writes to x0 are never forwarded
    put(3'b000, 5'd11, 32'd5, 5'd12, 32'd6, 5'd0);
    step();
    put(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd13);
    wb_rd = 5'd0; wb_reg_write = 1; wb_data = 32'd99;
    step();
    clr_in();
    step();
    chk("x0_no_fwd", mem_alu_result, 32'd0);

    // flush beats stall
    put(3'b000, 5'd1, 32'd1, 5'd2, 32'd1, 5'd5);
    flush = 1; stall = 1;
    step();
    clr_in();
    step();
    chk("flush_bubble", mem_valid, 0);

    // stall holds ID/EX for 3 cycles
    put(3'b000, 5'd14, 32'd100, 5'd15, 32'd23, 5'd4);
    step();
    put(3'b011, 5'd1, 32'd5, 5'd2, 32'd6, 5'd7);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_res", mem_alu_result, 32'd123);
      chk("stall_ex_rd", ex_rd, 5'd4);
    end
    clr_in();
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_valid       = ($urandom_range(0, 9) < 8);
      id_pc          = $urandom & 32'hFFFF_FFFC;
      id_rs1_data    = rand_val();
      id_rs2_data    = rand_val();
      id_imm         = rand_val();
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_rd          = 5'($urandom_range(0, 3));
      id_alu_control = 3'($urandom_range(0, 7));
      id_alu_src     = 1'($urandom_range(0, 1));
      id_reg_write   = 1'($urandom_range(0, 1));
      id_mem_write   = 1'($urandom_range(0, 1));
      id_branch      = ($urandom_range(0, 3) == 0);
      id_jump        = ($urandom_range(0, 7) == 0);
      id_result_src  = 2'($urandom_range(0, 2));
      stall          = ($urandom_range(0, 99) < 15);
      flush          = ($urandom_range(0, 99) < 10);
      wb_rd          = 5'($urandom_range(0, 3));
      wb_reg_write   = 1'($urandom_range(0, 1));
      wb_data        = rand_val();
      step();
    end

    // asynchronous reset in the middle of a stream
    clr_in();
    put(3'b000, 5'd1, 32'd10, 5'd2, 32'd20, 5'd1);
    step();
    put(3'b011, 5'd1, 32'd0, 5'd2, 32'd3, 5'd2);
    step();
    #2;
    rst = 1;
    #1;
    m_ex  = '{default: 0};
    m_mem = '{default: 0};
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_mem_alu_result", mem_alu_result, 0);
    chk("arst_mem_reg_write", mem_reg_write, 0);
    chk("arst_mem_pc_plus4", mem_pc_plus4, 0);
    chk("arst_pc_src", pc_src, 0);
    chk("arst_pc_target", pc_target, 0);
    @(posedge clk);
    #3;
    rst = 0;
    put(3'b000, 5'd1, 32'd2, 5'd2, 32'd3, 5'd6);
    step();
    chk("post_rst_bubble", mem_valid, 0);
    clr_in();
    step();
    chk("post_rst_first", mem_valid, 1);
    chk("post_rst_res", mem_alu_result, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
